// File: rtl/fx_meter.sv
// Reciprocal frequency/period meter: counts whole fx_in periods and clkin cycles
// over a gate window that opens and closes on synchronized fx_in rising edges.
module fx_meter #(
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clkin,
   input  logic             nrst,
   input  logic             fx_in,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] gate_len,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] fx_res,
   output logic [CNT_W-1:0] ref_res,
   output logic             tmo
);

   localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_MEAS,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [SYNC_N-1:0] sync_q;
   logic             hist_q;
   logic             fx_rise;
   logic [CNT_W-1:0] g_q, g_d;
   logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
   logic [CNT_W-1:0] fx_cnt_q, fx_cnt_d;
   logic [CNT_W-1:0] ref_inc, fx_inc;
   logic             at_max, closing;
   logic             busy_d, done_d, tmo_d;
   logic [CNT_W-1:0] fx_res_d, ref_res_d;

   // fx_in synchronizer plus history flop for rising-edge detection
   always_ff @(posedge clkin or negedge nrst) begin
      if (!nrst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_N-2:0], fx_in};
         hist_q <= sync_q[SYNC_N-1];
      end
   end

   assign fx_rise = sync_q[SYNC_N-1] & ~hist_q;

   // Counters saturate at all-ones; a rise at the saturated count still closes the gate
   assign at_max  = (ref_cnt_q == CNT_MAX);
   assign ref_inc = at_max ? CNT_MAX : ref_cnt_q + CNT_W'(1);
   assign fx_inc  = fx_cnt_q + CNT_W'(1);
   assign closing = fx_rise && (ref_inc >= g_q);

   // State, counter and result registers
   always_ff @(posedge clkin or negedge nrst) begin
      if (!nrst) begin
         state_q   <= S_IDLE;
         g_q       <= '0;
         ref_cnt_q <= '0;
         fx_cnt_q  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tmo       <= 1'b0;
         fx_res    <= '0;
         ref_res   <= '0;
      end else begin
         state_q   <= state_d;
         g_q       <= g_d;
         ref_cnt_q <= ref_cnt_d;
         fx_cnt_q  <= fx_cnt_d;
         busy      <= busy_d;
         done      <= done_d;
         tmo       <= tmo_d;
         fx_res    <= fx_res_d;
         ref_res   <= ref_res_d;
      end
   end

   // Next-state, counter and output logic
   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      ref_cnt_d = ref_cnt_q;
      fx_cnt_d  = fx_cnt_q;
      busy_d    = busy;
      done_d    = 1'b0;
      tmo_d     = tmo;
      fx_res_d  = fx_res;
      ref_res_d = ref_res;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               g_d       = (gate_len == '0) ? CNT_W'(1) : gate_len;
               ref_cnt_d = '0;
               fx_cnt_d  = '0;
               busy_d    = 1'b1;
               state_d   = S_ARM;
            end
         end
         S_ARM: begin
            ref_cnt_d = ref_inc;
            if (fx_rise) begin
               ref_cnt_d = '0;
               fx_cnt_d  = '0;
               state_d   = S_MEAS;
            end else if (at_max) begin
               state_d   = S_DONE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               fx_res_d  = fx_cnt_q;
               ref_res_d = ref_cnt_q;
               tmo_d     = 1'b1;
            end
         end
         S_MEAS: begin
            ref_cnt_d = ref_inc;
            if (fx_rise) begin
               fx_cnt_d = fx_inc;
            end
            if (closing) begin
               state_d   = S_DONE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               fx_res_d  = fx_inc;
               ref_res_d = ref_inc;
               tmo_d     = 1'b0;
            end else if (at_max) begin
               state_d   = S_DONE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               fx_res_d  = fx_cnt_q;
               ref_res_d = ref_cnt_q;
               tmo_d     = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides everything and leaves the previous results untouched
      if (abort) begin
         state_d   = S_IDLE;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         tmo_d     = tmo;
         fx_res_d  = fx_res;
         ref_res_d = ref_res;
      end
   end

endmodule

// File: tb/tb_fx_meter.sv
// Self-checking bench for fx_meter: timestamp-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized measurements.
module tb_fx_meter;

   localparam int unsigned CNT_W = 8;
   localparam int unsigned S     = 2;
   localparam longint      MAXV  = (longint'(1) << CNT_W) - 1;

   logic             clkin = 1'b0;
   logic             nrst  = 1'b1;
   logic             fx_in = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] gate_len = '0;
   logic             busy, done, tmo;
   logic [CNT_W-1:0] fx_res, ref_res;

   int vectors     = 0;
   int miscompares = 0;
   int dut_dones   = 0;
   bit chk_en      = 1'b0;
   int fx_half     = 0;
   int fx_ph       = 0;

   fx_meter #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
      .clkin    (clkin),
      .nrst     (nrst),
      .fx_in    (fx_in),
      .start    (start),
      .abort    (abort),
      .gate_len (gate_len),
      .busy     (busy),
      .done     (done),
      .fx_res   (fx_res),
      .ref_res  (ref_res),
      .tmo      (tmo)
   );

   always #5 clkin = ~clkin;

   // Reference model: measurement phases tracked by edge timestamps
   int               m_mode = 0;   // 0 idle, 1 waiting for opening edge, 2 gate open, 3 result cycle
   longint           cyc = 0, arm_t = 0, open_t = 0, el = 0, mg = 1;
   int               nr = 0;
   logic             h [1:S+1];
   logic             rise;
   logic             e_busy = 1'b0, e_done = 1'b0, e_tmo = 1'b0;
   logic [CNT_W-1:0] e_fx = '0, e_ref = '0;

   task automatic m_finish(input int f, input longint r, input logic t);
      m_mode = 3;
      e_done = 1'b1;
      e_fx   = CNT_W'(f);
      e_ref  = CNT_W'(r);
      e_tmo  = t;
   endtask

   always @(posedge clkin or negedge nrst) begin
      if (!nrst) begin
         m_mode = 0;
         e_busy = 1'b0; e_done = 1'b0; e_tmo = 1'b0;
         e_fx   = '0;   e_ref  = '0;
         for (int i = 1; i <= S + 1; i++) h[i] = 1'b0;
      end else begin
         cyc++;
         // input rise becomes visible S edges after it is first sampled
         rise = h[S] && !h[S+1];
         for (int i = S + 1; i >= 2; i--) h[i] = h[i-1];
         h[1] = fx_in;
         e_done = 1'b0;
         case (m_mode)
            0: if (start && !abort) begin
                  m_mode = 1;
                  arm_t  = cyc + 1;
                  mg     = (gate_len == '0) ? 1 : longint'(gate_len);
               end
            1: if (abort) m_mode = 0;
               else if (rise) begin
                  m_mode = 2; open_t = cyc; nr = 0;
               end else if (cyc - arm_t == MAXV) m_finish(0, MAXV, 1'b1);
            2: begin
                  el = cyc - open_t;
                  if (abort) m_mode = 0;
                  else begin
                     if (rise) nr++;
                     if (rise && el >= mg) m_finish(nr, (el > MAXV) ? MAXV : el, 1'b0);
                     else if (el - 1 == MAXV) m_finish(nr, MAXV, 1'b1);
                  end
               end
            default: m_mode = 0;
         endcase
         e_busy = (m_mode == 1) || (m_mode == 2);
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clkin) begin
      if (chk_en) begin
         vectors++;
         if ({busy, done, tmo, fx_res, ref_res} !== {e_busy, e_done, e_tmo, e_fx, e_ref}) begin
            miscompares++;
            $display("FAIL cycle_compare t=%0t busy/done/tmo/fx/ref got %b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                     $time, busy, done, tmo, fx_res, ref_res, e_busy, e_done, e_tmo, e_fx, e_ref);
         end
         if (done) dut_dones++;
      end
   end

   task automatic chk(input string nm, input longint got, input longint exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic fx_step();
      if (fx_half == 0) begin
         fx_in = 1'b0;
         fx_ph = 0;
      end else begin
         fx_ph++;
         if (fx_ph >= fx_half) begin
            fx_in = ~fx_in;
            fx_ph = 0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clkin);
      fx_step();
   endtask

   task automatic cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic do_start(input logic [CNT_W-1:0] gl);
      gate_len = gl;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int k = 0;
      while (!done && k < budget) begin
         tick();
         k++;
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL %s: no done within %0d cycles", nm, budget);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, k;
      #2 nrst = 1'b0;
      #1 chk_en = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fx", fx_res, 0);
      chk("rst_ref", ref_res, 0);
      chk("rst_tmo", tmo, 0);
      cycles(3);
      nrst = 1'b1;

      // basic: period 4, gate 10
      fx_half = 2;
      cycles(10);
      d0 = dut_dones;
      do_start(CNT_W'(10));
      wait_done("basic_done", 200);
      chk("basic_fx", fx_res, 3);
      chk("basic_ref", ref_res, 12);
      chk("basic_tmo", tmo, 0);
      chk("basic_model_fx", e_fx, 3);
      chk("basic_model_ref", e_ref, 12);
      tick();
      chk("basic_busy_after", busy, 0);
      cycles(20);
      chk("basic_done_count", dut_dones - d0, 1);

      // zero gate: period 6
      fx_half = 3;
      cycles(10);
      do_start('0);
      wait_done("zero_done", 200);
      chk("zero_fx", fx_res, 1);
      chk("zero_ref", ref_res, 6);

      // ARM timeout with fx held low
      fx_half = 0;
      cycles(6);
      do_start(CNT_W'(10));
      wait_done("tmo_done", 300);
      chk("tmo_flag", tmo, 1);
      chk("tmo_fx", fx_res, 0);
      chk("tmo_ref", ref_res, 255);
      chk("tmo_model_ref", e_ref, 255);

      // abort mid-measurement keeps prior results
      fx_half = 2;
      cycles(10);
      do_start(CNT_W'(10));
      wait_done("pre_abort_done", 200);
      cycles(3);
      do_start(CNT_W'(100));
      cycles(20);
      d0 = dut_dones;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_fx", fx_res, 3);
      chk("abort_ref", ref_res, 12);
      cycles(150);
      chk("abort_no_done", dut_dones - d0, 0);
      do_start(CNT_W'(10));
      wait_done("after_abort_done", 200);
      chk("after_abort_fx", fx_res, 3);
      chk("after_abort_ref", ref_res, 12);

      // second start during MEAS is ignored
      cycles(3);
      do_start(CNT_W'(10));
      cycles(6);
      do_start('0);
      wait_done("restart_done", 200);
      chk("restart_fx", fx_res, 3);
      chk("restart_ref", ref_res, 12);

      // start and abort together in IDLE
      cycles(3);
      d0 = dut_dones;
      gate_len = CNT_W'(10);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", busy, 0);
      cycles(30);
      chk("start_abort_no_done", dut_dones - d0, 0);

      // async reset mid-measurement
      do_start(CNT_W'(200));
      cycles(30);
      @(posedge clkin);
      #2 nrst = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_fx", fx_res, 0);
      chk("arst_ref", ref_res, 0);
      chk("arst_tmo", tmo, 0);
      d0 = dut_dones;
      cycles(3);
      nrst = 1'b1;
      cycles(300);
      chk("arst_no_done", dut_dones - d0, 0);
      chk("arst_idle", busy, 0);

      // randomized measurements with occasional abort / stray start
      for (int t = 0; t < 40; t++) begin
         fx_half = $urandom_range(0, 12);
         cycles($urandom_range(1, 8));
         do_start(CNT_W'($urandom_range(0, 255)));
         k = 0;
         while ((busy || done) && k < 700) begin
            if ($urandom_range(0, 199) == 0) abort = 1'b1;
            if ($urandom_range(0, 29) == 0) begin
               start    = 1'b1;
               gate_len = CNT_W'($urandom);
            end
            tick();
            abort = 1'b0;
            start = 1'b0;
            k++;
         end
         chk("rand_settle", (k < 700) ? 1 : 0, 1);
      end

      cycles(5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fx_meter.md
Name: fx_meter

Overview:
- Reciprocal frequency/period meter downstream of the frequency-counter divider; consumes the (optionally /8) measured clock fx_out as input fx_in.
- Counts whole input periods and reference cycles over a gate window aligned to input rising edges, giving an exact edge-to-edge ratio.
- Results are latched for register readback over SPI; done drives the interrupt/status path.

Parameters:
CNT_W, 24, width of the period counter, the reference counter and the gate length.
SYNC_STAGES, 2, synchronizer flops on fx_in (minimum 2).

Ports:
clkin  input  1  reference clock; all logic is on its rising edge.
nrst  input  1  asynchronous active-low reset.
fx_in  input  1  measured signal, asynchronous to clkin.
start  input  1  one-cycle pulse that starts a measurement; acted on only in IDLE.
abort  input  1  cancels a measurement in any state.
gate_len  input  CNT_W  minimum gate length in clkin cycles; sampled at start.
busy  output  1  high in ARM and MEAS.
done  output  1  one-cycle pulse when results update.
fx_res  output  CNT_W  counted input periods.
ref_res  output  CNT_W  clkin cycles spanning fx_res periods.
tmo  output  1  last measurement ended by timeout.

Behaviour:
- Reset: state IDLE; busy, done, tmo = 0; fx_res, ref_res = 0; synchronizer and internal counters = 0.
- Input conditioning:
  - fx_in passes through SYNC_STAGES flops plus one history flop.
  - fx_rise = sync & ~hist.
  - fx_rise is asserted SYNC_STAGES+1 cycles after the input edge and is one cycle wide.
- FSM states: IDLE, ARM, MEAS, DONE.
- IDLE:
  - start: latch g = (gate_len==0) ? 1 : gate_len; clear ref_cnt and fx_cnt; go to ARM.
- ARM:
  - ref_cnt increments every cycle (acts as the timeout counter).
  - On fx_rise: ref_cnt = 0, fx_cnt = 0, go to MEAS. This edge opens the gate.
- MEAS, each cycle:
  - ref_cnt += 1.
  - If fx_rise: fx_cnt += 1, and if (ref_cnt+1) >= g, close the gate and go to DONE. The closing edge and its cycle are included in the counts.
- Timeout: in ARM or MEAS, if ref_cnt == all-ones and the gate is not closing that cycle, go to DONE with tmo_next = 1. An ARM timeout gives fx_cnt = 0.
- DONE, exactly one cycle:
  - fx_res = fx_cnt, ref_res = ref_cnt, tmo = tmo_next; done = 1.
  - Next state is IDLE.
  - Results and tmo hold until the next DONE.
- busy is registered: it rises the cycle after the accepted start and falls in the DONE cycle (the same cycle done is high).
- Ignored inputs: start outside IDLE, and start during DONE.
- abort:
  - Has highest priority, above start and above gate closing.
  - Next state is IDLE, busy drops next cycle, no done pulse.
  - fx_res, ref_res and tmo retain their previous values.
- Arithmetic: all counters are unsigned CNT_W bits and never wrap; fx_cnt <= ref_cnt by construction.
- Reset mid-measurement: immediate return to the reset state; no done.

Test Plan:
- Basic measurement. fx_in period 4 cycles, gate_len=10, start → edges at t0 (open), t4, t8, t12; at t12 ref reaches 12 >= 10.
  - Required: done once; fx_res=3, ref_res=12, tmo=0; busy low after done.
- Zero gate. gate_len=0, fx_in period 6.
  - Required: gate closes on the first edge after opening; fx_res=1, ref_res=6.
- ARM timeout. CNT_W=8, fx_in held low, start.
  - Required: done about 256 cycles later; tmo=1, fx_res=0, ref_res=255.
- Abort mid-MEAS. Abort with prior results fx_res=3, ref_res=12.
  - Required: no done; busy=0 next cycle; fx_res=3, ref_res=12 unchanged; a new start then measures normally.
- Start while busy. Second start pulse during MEAS.
  - Required: ignored; results match the single-start case. Also run with start and abort in the same cycle in IDLE → stays IDLE.
- Async reset mid-MEAS. Assert nrst low mid-measurement.
  - Required: all outputs 0 immediately; state IDLE; no done after release.
